// File: rtl/huff_pkg.sv
// Shared node layout, field bounds and sorter state encoding.
package huff_pkg;

    localparam int unsigned NODE_W    = 13;
    localparam int unsigned WEIGHT_HI = 12;
    localparam int unsigned WEIGHT_LO = 5;
    localparam int unsigned WEIGHT_W  = WEIGHT_HI - WEIGHT_LO + 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } sort_state_e;

    function automatic logic [WEIGHT_W-1:0] node_weight(input logic [NODE_W-1:0] node);
        return node[WEIGHT_HI:WEIGHT_LO];
    endfunction

endpackage

// File: rtl/node_cmp_swap.sv
// Combinational compare-swap of two nodes on their weight field; ties keep a before b.
module node_cmp_swap
    import huff_pkg::*;
(
    input  logic [NODE_W-1:0] a,
    input  logic [NODE_W-1:0] b,
    output logic [NODE_W-1:0] lo,
    output logic [NODE_W-1:0] hi,
    output logic              swapped
);

    always_comb begin
        swapped = node_weight(a) > node_weight(b);
        lo      = swapped ? b : a;
        hi      = swapped ? a : b;
    end

endmodule

// File: rtl/node_sorter.sv
// Batch bubble sorter: load DEPTH nodes, sort lightest first, drain with valid/ready.
// Optional SORT_EARLY_EXIT_EN ends SORT after the first pass that makes no swap.
module node_sorter
    import huff_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NODE_W = huff_pkg::NODE_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    input  logic [NODE_W-1:0] load_node,
    output logic              load_ready,
    output logic              out_valid,
    output logic [NODE_W-1:0] out_node,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 2);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);
`ifdef SORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    sort_state_e       state;
    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  pass;
    logic [IDX_W-1:0]  rd_ptr;
    logic              swap_seen;
    logic [NODE_W-1:0] entry     [DEPTH];
    logic [NODE_W-1:0] entry_nxt [DEPTH];

    logic [IDX_W-1:0]  idx_p1;
    logic [IDX_W-1:0]  rd_ptr_p1;
    logic [NODE_W-1:0] cmp_lo;
    logic [NODE_W-1:0] cmp_hi;
    logic              cmp_swapped;
    logic              pass_swapped;
    logic              sort_done;

    node_cmp_swap u_cmp (
        .a       (entry[idx]),
        .b       (entry[idx_p1]),
        .lo      (cmp_lo),
        .hi      (cmp_hi),
        .swapped (cmp_swapped)
    );

    // Index arithmetic and the end-of-sort decision for the current compare.
    always_comb begin
        idx_p1       = idx + IDX_W'(1);
        rd_ptr_p1    = rd_ptr + IDX_W'(1);
        pass_swapped = (idx == '0) ? cmp_swapped : (swap_seen | cmp_swapped);
        sort_done    = (idx == IDX_LAST) &&
                       ((pass == IDX_LAST) || (EARLY_EXIT && !pass_swapped));
    end

    // Next contents of the node store: a load write or the compare-swap result.
    always_comb begin
        entry_nxt = entry;
        if (state == ST_LOAD && load_valid) begin
            entry_nxt[wr_cnt] = load_node;
        end else if (state == ST_SORT) begin
            entry_nxt[idx]    = cmp_lo;
            entry_nxt[idx_p1] = cmp_hi;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_LOAD;
            wr_cnt     <= '0;
            idx        <= '0;
            pass       <= '0;
            rd_ptr     <= '0;
            swap_seen  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) entry[i] <= '0;
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            out_node   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            entry <= entry_nxt;
            case (state)
                ST_LOAD: begin
                    if (load_valid) begin
                        if (wr_cnt == PTR_LAST) begin
                            wr_cnt     <= '0;
                            idx        <= '0;
                            pass       <= '0;
                            state      <= ST_SORT;
                            load_ready <= 1'b0;
                            busy       <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + IDX_W'(1);
                        end
                    end
                end
                ST_SORT: begin
                    swap_seen <= pass_swapped;
                    if (idx == IDX_LAST) begin
                        idx <= '0;
                        if (sort_done) begin
                            pass      <= '0;
                            rd_ptr    <= '0;
                            state     <= ST_DRAIN;
                            out_valid <= 1'b1;
                            out_node  <= entry_nxt[0];
                            out_last  <= 1'b0;
                        end else begin
                            pass <= pass + IDX_W'(1);
                        end
                    end else begin
                        idx <= idx_p1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr == PTR_LAST) begin
                            rd_ptr     <= '0;
                            state      <= ST_LOAD;
                            load_ready <= 1'b1;
                            busy       <= 1'b0;
                            out_valid  <= 1'b0;
                            out_node   <= '0;
                            out_last   <= 1'b0;
                        end else begin
                            rd_ptr   <= rd_ptr_p1;
                            out_node <= entry[rd_ptr_p1];
                            out_last <= (rd_ptr_p1 == PTR_LAST);
                        end
                    end
                end
                default: begin
                    state      <= ST_LOAD;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/node_sorter.md
NODE_SORTER -- requirements
Module: node_sorter

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of nodes per sort batch (2..16).
REQ-002 SHALL have parameter NODE_W, default 13: node width; bits [12:5] hold the weight and bits [4:0] hold the symbol.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port load_valid, input, 1 bit: load_node is valid this cycle.
REQ-006 SHALL have port load_node, input, NODE_W bits: node to be loaded.
REQ-007 SHALL have port load_ready, output, 1 bit: the block accepts a load beat.
REQ-008 SHALL have port out_valid, output, 1 bit: out_node is valid this cycle.
REQ-009 SHALL have port out_node, output, NODE_W bits: sorted node, lightest first.
REQ-010 SHALL have port out_last, output, 1 bit: marks the final node of the batch.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts an out beat.
REQ-012 SHALL have port busy, output, 1 bit: high in the SORT and DRAIN states.

Function
REQ-013 SHALL implement three states: LOAD, SORT and DRAIN.
- RST enters LOAD.
REQ-014 SHALL, in LOAD, drive load_ready=1.
- Each cycle with load_valid&&load_ready writes load_node to entry[wr_cnt] and increments wr_cnt.
- The beat that makes wr_cnt reach DEPTH moves the state to SORT on the next cycle.
REQ-015 SHALL drive load_ready=0 in SORT and DRAIN, and SHALL ignore load_valid in those states.
REQ-016 SHALL, in SORT, perform exactly one compare-swap per cycle on entry[idx] and entry[idx+1], then increment idx.
- idx runs 0..DEPTH-2, then wraps to 0 and pass is incremented.
REQ-017 SHALL swap a pair only when the weight of entry[idx] is strictly greater than the weight of entry[idx+1].
- Equal weights keep their order, so the sort is stable.
REQ-018 SHALL compare weights as unsigned 8-bit values; the symbol bits SHALL never affect ordering.
REQ-019 SHALL leave SORT after the compare with pass=DEPTH-2 and idx=DEPTH-2.
- SORT lasts (DEPTH-1)^2 cycles, which is 49 at the default DEPTH.
REQ-020 SHALL, in DRAIN, drive out_valid=1 and out_node=entry[rd_ptr].
- rd_ptr starts at 0 and advances on out_valid&&out_ready.
REQ-021 SHALL drive out_last=1 exactly when rd_ptr=DEPTH-1 in DRAIN.
REQ-022 SHALL hold out_node and out_valid stable while out_ready=0.
REQ-023 SHALL return to LOAD with wr_cnt=0 on the cycle after the out_last beat is accepted.
- load_ready SHALL be 1 on that cycle.
REQ-024 SHALL drive out_valid low at all times outside DRAIN.

Reset
REQ-025 SHALL, on RST at any cycle including mid-SORT or mid-DRAIN, set state=LOAD, wr_cnt=0, idx=0, pass=0, rd_ptr=0 and clear all entries to 0.
- Partial batches are discarded.
REQ-026 SHALL drive the following output values during and after reset: load_ready=1, out_valid=0, out_node=0, out_last=0, busy=0.

Configuration
REQ-027 SHALL support macro SORT_EARLY_EXIT_EN.
- When defined: a swap flag is cleared at idx=0 and set on any swap; a pass that completes with no swap moves the state to DRAIN immediately.
- When defined, an already-sorted batch spends exactly DEPTH-1 cycles in SORT.
- When undefined: SORT always lasts (DEPTH-1)^2 cycles, independent of the data.

Structure
REQ-028 SHALL take NODE_W, the weight field bounds WEIGHT_HI=12 and WEIGHT_LO=5, and the state enumeration from shared package huff_pkg.
REQ-029 SHALL place the compare-swap in one combinational sub-module, node_cmp_swap, with inputs a and b and outputs lo, hi and swapped.

Verification
REQ-030 SHALL cover reverse order: load weights 8,7,6,5,4,3,2,1 -> out weights 1..8, out_valid rising 50 cycles after the 8th load beat (macro undefined), out_last only on weight 8.
REQ-031 SHALL cover ties: load 0x0A1, 0x041, 0x0A2, 0x043, 0x011, 0x012, 0x0A3, 0x044 -> output order 0x011, 0x012, 0x041, 0x043, 0x044, 0x0A1, 0x0A2, 0x0A3.
REQ-032 SHALL cover early exit: with SORT_EARLY_EXIT_EN defined, load an already-sorted batch -> busy high for 7 SORT cycles, then DRAIN.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 5 cycles at rd_ptr=3 -> out_node stays unchanged and no beat is lost or duplicated.
REQ-034 SHALL cover reset mid-SORT: assert RST at SORT cycle 20 -> next cycle load_ready=1, out_valid=0, and a fresh 8-beat batch sorts correctly.
REQ-035 SHALL cover turnaround: accept the out_last beat -> next cycle load_ready=1; back-to-back batches sort correctly.
